// File: rtl/ex_stage_queue.sv
// ex_stage_queue: execute-stage output FIFO between ID and MEM.
// It also blocks wrong-path instructions while a taken branch is still queued.
module ex_stage_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rstn_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ack_o,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] result_i,
    input  logic            branch_i,
    input  logic            ack_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] result_o,
    output logic [XLEN-1:0] rs2_o,
    output logic            branch_o,
    output logic [CNTW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] result_q[DEPTH];
    logic [XLEN-1:0] rs2_q   [DEPTH];
    logic [DEPTH-1:0] br_q;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            blk_q, blk_d;
    logic            pop, push, full, head_br, blk_eff;

    assign valid_o  = cnt_q != '0;
    assign full     = cnt_q == CNTW'(DEPTH);
    assign head_br  = br_q[rd_q];
    assign pop      = valid_o && ack_i && !flush_i;
    // Popping the queued branch releases the block in the same cycle, so the
    // next instruction can be accepted alongside that pop.
    assign blk_eff  = blk_q && !(pop && head_br);
    assign ack_o    = valid_i && !flush_i && !blk_eff && (!full || pop);
    assign push     = ack_o;

    assign instr_o  = instr_q[rd_q];
    assign pc_o     = pc_q[rd_q];
    assign result_o = result_q[rd_q];
    assign rs2_o    = rs2_q[rd_q];
    assign branch_o = head_br && valid_o;
    assign count_o  = cnt_q;

    always_comb begin
        wr_d  = flush_i ? '0 : push ? wr_q + AW'(1) : wr_q;
        rd_d  = flush_i ? '0 : pop ? rd_q + AW'(1) : rd_q;
        cnt_d = flush_i ? '0 :
                (push && !pop) ? cnt_q + CNTW'(1) :
                (pop && !push) ? cnt_q - CNTW'(1) : cnt_q;
        blk_d = flush_i ? 1'b0 :
                (push && branch_i) ? 1'b1 :
                (pop && head_br) ? 1'b0 : blk_q;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            blk_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            blk_q <= blk_d;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            br_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i]  <= '0;
                pc_q[i]     <= '0;
                result_q[i] <= '0;
                rs2_q[i]    <= '0;
            end
        end else if (push) begin
            br_q[wr_q]     <= branch_i;
            instr_q[wr_q]  <= instr_i;
            pc_q[wr_q]     <= pc_i;
            result_q[wr_q] <= result_i;
            rs2_q[wr_q]    <= rs2_i;
        end
    end
endmodule

// File: tb/tb_ex_stage_queue.sv
// tb_ex_stage_queue: directed checks of ex_stage_queue at DEPTH=2 and DEPTH=4.
// Both instances share the stimulus; each phase checks the instance it targets.
module tb_ex_stage_queue;
    logic        clk = 1'b0;
    logic        rstn_i, flush_i, valid_i, branch_i, ack_i;
    logic [31:0] instr_i, pc_i, rs2_i, result_i;

    logic        a2, v2, b2, a4, v4, b4;
    logic [31:0] ins2, pc2, res2, r22, ins4, pc4, res4, r24;
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;

    int vectors = 0;
    int errors  = 0;

    ex_stage_queue #(.XLEN(32), .DEPTH(2)) d2 (
        .clk(clk), .rstn_i(rstn_i), .flush_i(flush_i), .valid_i(valid_i), .ack_o(a2),
        .instr_i(instr_i), .pc_i(pc_i), .rs2_i(rs2_i), .result_i(result_i),
        .branch_i(branch_i), .ack_i(ack_i), .valid_o(v2), .instr_o(ins2), .pc_o(pc2),
        .result_o(res2), .rs2_o(r22), .branch_o(b2), .count_o(cnt2)
    );

    ex_stage_queue #(.XLEN(32), .DEPTH(4)) d4 (
        .clk(clk), .rstn_i(rstn_i), .flush_i(flush_i), .valid_i(valid_i), .ack_o(a4),
        .instr_i(instr_i), .pc_i(pc_i), .rs2_i(rs2_i), .result_i(result_i),
        .branch_i(branch_i), .ack_i(ack_i), .valid_o(v4), .instr_o(ins4), .pc_o(pc4),
        .result_o(res4), .rs2_o(r24), .branch_o(b4), .count_o(cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rstn_i = 1'b0;
        #2;
        rstn_i = 1'b1;
    endtask

    initial begin
        rstn_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; branch_i = 1'b0; ack_i = 1'b0;
        instr_i = '0; pc_i = '0; rs2_i = '0; result_i = '0;
        #12;
        chk("rst_count", 32'(cnt4), 32'd0);
        chk("rst_valid", 32'(v4), 32'd0);
        chk("rst_branch", 32'(b4), 32'd0);
        chk("rst_pc", pc4, 32'd0);
        chk("rst_result", res4, 32'd0);
        rstn_i = 1'b1;

        // single push then pop
        valid_i = 1'b1; pc_i = 32'h100; result_i = 32'h2A; instr_i = 32'h13; rs2_i = 32'h55;
        #1 chk("single_ack", 32'(a4), 32'd1);
        step();
        valid_i = 1'b0;
        chk("single_valid", 32'(v4), 32'd1);
        chk("single_pc", pc4, 32'h100);
        chk("single_result", res4, 32'h2A);
        chk("single_instr", ins4, 32'h13);
        chk("single_rs2", r24, 32'h55);
        chk("single_count", 32'(cnt4), 32'd1);
        ack_i = 1'b1;
        step();
        chk("single_pop_count", 32'(cnt4), 32'd0);
        chk("single_pop_valid", 32'(v4), 32'd0);
        ack_i = 1'b0;

        // fill DEPTH=2 and stall, then push+pop while full
        valid_i = 1'b1; pc_i = 32'h0;
        #1 chk("fill_ack0", 32'(a2), 32'd1);
        step();
        pc_i = 32'h4;
        #1 chk("fill_ack1", 32'(a2), 32'd1);
        step();
        pc_i = 32'h8;
        #1 chk("fill_ack2", 32'(a2), 32'd0);
        chk("fill_count", 32'(cnt2), 32'd2);
        step();
        chk("stall_count", 32'(cnt2), 32'd2);
        chk("stall_head", pc2, 32'h0);
        ack_i = 1'b1;
        #1 chk("full_pushpop_ack", 32'(a2), 32'd1);
        step();
        valid_i = 1'b0;
        chk("full_pushpop_count", 32'(cnt2), 32'd2);
        chk("full_pushpop_head", pc2, 32'h4);
        step();
        chk("drain_head", pc2, 32'h8);
        chk("drain_count", 32'(cnt2), 32'd1);
        step();
        chk("drain_empty", 32'(cnt2), 32'd0);
        ack_i = 1'b0;
        pulse_reset();

        // pointer wrap on DEPTH=4 with MEM acking every cycle
        ack_i = 1'b1; valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_i = 32'h200 + 32'(4 * i);
            #1 chk("wrap_ack", 32'(a4), 32'd1);
            step();
            chk("wrap_valid", 32'(v4), 32'd1);
            chk("wrap_pc", pc4, 32'h200 + 32'(4 * i));
            chk("wrap_count", 32'(cnt4), 32'd1);
        end
        valid_i = 1'b0;
        step();
        chk("wrap_empty", 32'(cnt4), 32'd0);
        ack_i = 1'b0;
        pulse_reset();

        // branch block
        valid_i = 1'b1; pc_i = 32'h20; branch_i = 1'b1;
        #1 chk("br_ack", 32'(a4), 32'd1);
        step();
        chk("br_head_branch", 32'(b4), 32'd1);
        chk("br_head_pc", pc4, 32'h20);
        pc_i = 32'h24; branch_i = 1'b0;
        #1 chk("br_block_ack", 32'(a4), 32'd0);
        step();
        chk("br_block_count", 32'(cnt4), 32'd1);
        chk("br_block_head", pc4, 32'h20);
        ack_i = 1'b1;
        #1 chk("br_release_ack", 32'(a4), 32'd1);
        step();
        valid_i = 1'b0; ack_i = 1'b0;
        chk("br_after_pc", pc4, 32'h24);
        chk("br_after_count", 32'(cnt4), 32'd1);
        chk("br_after_branch", 32'(b4), 32'd0);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        chk("br_drain", 32'(cnt4), 32'd0);

        // flush with count=3 and block set
        valid_i = 1'b1; pc_i = 32'h30;
        #1 chk("fl_ack0", 32'(a4), 32'd1);
        step();
        pc_i = 32'h34;
        #1 chk("fl_ack1", 32'(a4), 32'd1);
        step();
        pc_i = 32'h38; branch_i = 1'b1;
        #1 chk("fl_ack2", 32'(a4), 32'd1);
        step();
        pc_i = 32'h3C; branch_i = 1'b0;
        chk("fl_count3", 32'(cnt4), 32'd3);
        #1 chk("fl_blocked", 32'(a4), 32'd0);
        flush_i = 1'b1; ack_i = 1'b1;
        #1 chk("fl_ack_flush", 32'(a4), 32'd0);
        step();
        flush_i = 1'b0; ack_i = 1'b0;
        chk("fl_count0", 32'(cnt4), 32'd0);
        chk("fl_valid0", 32'(v4), 32'd0);
        chk("fl_branch0", 32'(b4), 32'd0);
        pc_i = 32'h40;
        #1 chk("fl_new_ack", 32'(a4), 32'd1);
        step();
        chk("fl_new_pc", pc4, 32'h40);
        chk("fl_new_count", 32'(cnt4), 32'd1);

        // asynchronous reset between edges
        pc_i = 32'h44;
        step();
        valid_i = 1'b0;
        chk("ar_count2", 32'(cnt4), 32'd2);
        #2 rstn_i = 1'b0;
        #1;
        chk("ar_count", 32'(cnt4), 32'd0);
        chk("ar_valid", 32'(v4), 32'd0);
        chk("ar_branch", 32'(b4), 32'd0);
        chk("ar_pc", pc4, 32'd0);
        rstn_i = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
